// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer (FETCH/DECODE/EXECUTE/MEM/WB).
// Strobes are decoded combinationally from the current state and the ready/flag
// inputs; only the state, the illegal-trap flag and the optional performance
// counters are registered.
// Optional feature: define PERF_CNT_EN to build the busy-cycle and retired-
// instruction counters; otherwise both counter ports are tied to zero.
module exec_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [6:0]  opcode,
    input  logic        BranchTaken,
    input  logic        RegWrite,
    input  logic        MemWrite,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        ex_en,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  state,
    output logic        busy,
    output logic        illegal,
    output logic        instr_done,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_RSVD    = 3'd7
    } state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_e state_q, state_d;
    logic   illegal_q;
    logic   is_r, is_ld, is_sd, is_beq, is_legal;
    logic   retire;
    state_e retire_nxt;

    // Opcode classification; the instruction register holds opcode stable
    // from DECODE until the instruction retires.
    always_comb begin
        is_r     = (opcode == OP_RTYPE);
        is_ld    = (opcode == OP_LD);
        is_sd    = (opcode == OP_SD);
        is_beq   = (opcode == OP_BEQ);
        is_legal = is_r | is_ld | is_sd | is_beq;
    end

    // Retire detection: BEQ in EXECUTE, store on its last MEM cycle, or WB.
    always_comb begin
        retire     = 1'b0;
        retire_nxt = stop ? S_IDLE : S_FETCH;
        case (state_q)
            S_EXECUTE: retire = is_beq;
            S_MEM:     retire = dmem_ready & ~is_ld;
            S_WB:      retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (imem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = is_legal ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
                if (is_ld | is_sd)  state_d = S_MEM;
                else if (is_r)      state_d = S_WB;
                else if (is_beq)    state_d = retire_nxt;
                else                state_d = S_HALT;
            end
            S_MEM:     if (dmem_ready) state_d = is_ld ? S_WB : retire_nxt;
            S_WB:      state_d = retire_nxt;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase
    end

    // State and trap flag; the trap flag follows entry into the absorbing HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_d == S_HALT);
        end
    end

    // Strobe decode from current state, ready inputs and execute-stage flags.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        ex_en      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_sel     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXECUTE: begin
                ex_en  = 1'b1;
                pc_sel = is_beq & BranchTaken;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
            end
            S_WB: rf_we = RegWrite;
            default: ;
        endcase
        pc_we      = retire;
        instr_done = retire;
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXECUTE) || (state_q == S_MEM) ||
                     (state_q == S_WB);

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    // Performance counters; wrap naturally and hold whenever not busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            if (busy)       cycle_q   <= cycle_q + 32'd1;
            if (instr_done) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule
